mp_add_seq: RTL

Multi-precision add/subtract sequencer that time-shares one 16-bit carry-select adder across NWORDS-word operands. Operand words stream in least-significant word first; the block chains the carry between words through a register. Result words stream out through a registered valid/ready output stage. It sits between an operand source (register file or DMA) and a result sink, as the only user of its adder instance.

---
 rtl/mp_add_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer sharing one 16-bit carry-select adder.
// Latency: each result word is registered and valid the cycle after its operand words are accepted.
// Backpressure: InReady drops while a result is held unaccepted (OutValid && !OutReady); no word is lost.
//
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   Start, Sub        begin an operation (sampled in IDLE), 0 = A+B, 1 = A-B
//   InValid/InReady   operand word handshake, A/B operand words, LSW first
//   OutValid/OutReady result word handshake, Sum result word, Last = most-significant word
//   Cout, Ovf         final carry and signed overflow, valid with OutValid && Last
//   Busy, Done        operation in progress, one-cycle completion pulse
module mp_add_seq #(
  parameter int NWORDS = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Sub,
  input  logic        InValid,
  output logic        InReady,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [15:0] Sum,
  output logic        Last,
  output logic        Cout,
  output logic        Ovf,
  output logic        Busy,
  output logic        Done
);

  // Counter is wide enough for NWORDS up to 16 (it reaches NWORDS after the last accept).
  localparam logic [4:0] LAST_IDX = 5'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [4:0]  count;
  logic        c_reg;
  logic        sub_r;

  logic [15:0] bx;
  logic [7:0]  lo_sum;
  logic        lo_c;
  logic [8:0]  hi0;
  logic [8:0]  hi1;
  logic [15:0] add_sum;
  logic        add_co;

  logic        accept;
  logic        is_last;
  logic        out_hs;

  // Subtraction is A + ~B + 1; the +1 enters as the initial carry (set from Sub at Start).
  assign bx = sub_r ? ~B : B;

  // Carry-select adder: the upper byte is computed for both carry-in values in parallel
  // and the lower byte's carry picks the right one.
  assign {lo_c, lo_sum} = {1'b0, A[7:0]} + {1'b0, bx[7:0]} + {8'b0, c_reg};
  assign hi0     = {1'b0, A[15:8]} + {1'b0, bx[15:8]};
  assign hi1     = {1'b0, A[15:8]} + {1'b0, bx[15:8]} + 9'd1;
  assign add_sum = {(lo_c ? hi1[7:0] : hi0[7:0]), lo_sum};
  assign add_co  = lo_c ? hi1[8] : hi0[8];

  // A new word may enter when the output register is empty or being drained this cycle.
  assign InReady = (state == RUN) && (!OutValid || OutReady);
  assign accept  = InValid && InReady;
  assign is_last = (count == LAST_IDX);
  assign out_hs  = OutValid && OutReady;
  assign Busy    = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Start) next_state = RUN;
      RUN:     if (accept && is_last) next_state = FLUSH;
      FLUSH:   if (out_hs && Last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count    <= 5'd0;
      c_reg    <= 1'b0;
      sub_r    <= 1'b0;
      OutValid <= 1'b0;
      Sum      <= 16'h0000;
      Last     <= 1'b0;
      Cout     <= 1'b0;
      Ovf      <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= (state == FLUSH) && out_hs && Last;

      if (state == IDLE && Start) begin
        sub_r <= Sub;
        c_reg <= Sub;
        count <= 5'd0;
      end

      if (accept) begin
        Sum      <= add_sum;
        c_reg    <= add_co;
        OutValid <= 1'b1;
        Last     <= is_last;
        count    <= count + 5'd1;
        if (is_last) begin
          Cout <= add_co;
          // Signed overflow: operands agree in sign but the result's sign differs.
          Ovf  <= (A[15] == bx[15]) && (add_sum[15] != A[15]);
        end
      end else if (out_hs) begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule
